// File: rtl/imem_port_arbiter_pkg.sv
// rtl/imem_port_arbiter_pkg.sv - shared constants for the IF/D memory port arbiter
package imem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_port_grant.sv
// rtl/imem_port_arbiter_port_grant.sv - IF/D priority select with starvation counter
module imem_port_arbiter_port_grant #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic if_valid,
  input  logic d_valid,
  input  logic flush,
  output logic if_grant,
  output logic d_grant
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_ok;
  logic             force_if;

  // D normally wins; a starved IF takes the port once the counter saturates.
  always_comb begin
    if_ok    = if_valid && !flush;
    force_if = (starve_cnt == LIMIT);
    if_grant = idle && if_ok && (!d_valid || force_if);
    d_grant  = idle && d_valid && !(if_ok && force_if);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (if_grant) begin
      starve_cnt <= '0;
    end else if (d_grant) begin
      if (!if_valid)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_inst,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  logic [1:0] state;
  logic       cur_req;
  logic       discard;
  logic       idle;
  logic       if_grant;
  logic       d_grant;

  // Gated by reset so the combinational readies also read 0 while reset is held.
  assign idle         = (state == ST_IDLE) && reset;
  assign if_req_ready = if_grant;
  assign d_req_ready  = d_grant;

  imem_port_arbiter_port_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_grant (
    .clock    (clock),
    .reset    (reset),
    .idle     (idle),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .flush    (flush),
    .if_grant (if_grant),
    .d_grant  (d_grant)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cur_req       <= REQ_IF;
      discard       <= 1'b0;
      if_rsp_valid  <= 1'b0;
      if_rsp_inst   <= '0;
      if_rsp_err    <= 1'b0;
      d_rsp_valid   <= 1'b0;
      d_rsp_rdata   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_grant) begin
            cur_req       <= REQ_D;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= d_req_addr;
            mem_req_we    <= d_req_we;
            mem_req_wdata <= d_req_wdata;
            mem_req_be    <= d_req_be;
            state         <= ST_ISSUE;
          end else if (if_grant) begin
            cur_req <= REQ_IF;
            if (is_misaligned(if_req_addr)) begin
              state <= ST_ERR;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {if_req_addr[31:2], 2'b00};
              mem_req_we    <= 1'b0;
              mem_req_wdata <= '0;
              mem_req_be    <= BE_ALL;
              state         <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (flush && cur_req == REQ_IF)
            discard <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            state   <= ST_IDLE;
            discard <= 1'b0;
            if (cur_req == REQ_D) begin
              d_rsp_valid <= 1'b1;
              d_rsp_rdata <= mem_req_we ? 32'h0 : mem_rsp_rdata;
            end else if (!(discard || flush)) begin
              if_rsp_valid <= 1'b1;
              if_rsp_inst  <= mem_rsp_rdata;
              if_rsp_err   <= 1'b0;
            end
          end else if (flush && cur_req == REQ_IF) begin
            discard <= 1'b1;
          end
        end
        ST_ERR: begin
          if_rsp_valid <= 1'b1;
          if_rsp_err   <= 1'b1;
          if_rsp_inst  <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_imem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic        if_rsp_err;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_wdata = '0;
  logic [3:0]  d_req_be = '0;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  imem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: one outstanding transaction described by its fields and progress.
  int          starve;
  bit          busy, kd, misal, acc, disc;
  logic [31:0] e_addr, e_wdata;
  bit          e_we;
  logic [3:0]  e_be;
  bit          p_if, p_d, p_err;
  logic [31:0] p_data;

  // Memory responder and bookkeeping.
  int          mem_cnt = 0;
  int          mem_lat = 1;
  int          stall_n = 0;
  bit          rdy_rand = 0;
  bit          spur_en = 0;
  logic [31:0] mem_fix = '0;
  int          cyc = 0, n_mreq = 0, n_ifp = 0, n_dp = 0, g_cyc = 0, p_cyc = 0;
  bit          gq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void rule(input bit ifv, input bit dv, input bit fl, input int st,
                               output bit ig, output bit dg);
    bit if_ok;
    if_ok = ifv && !fl;
    ig = 0;
    dg = 0;
    if (dv && if_ok) begin
      if (st == LIMIT) ig = 1; else dg = 1;
    end else if (dv) dg = 1;
    else if (if_ok) ig = 1;
  endfunction

  task automatic tick(input bit ifv, input logic [31:0] ifa, input bit dv, input logic [31:0] da,
                      input bit dwe, input logic [31:0] dwd, input logic [3:0] dbe, input bit fl);
    bit ig, dg, exp_mreq;
    @(negedge clock);
    cyc++;
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(p_if));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(p_d));
    if (p_if) begin
      check("if_rsp_inst", if_rsp_inst, p_data);
      check("if_rsp_err", 32'(if_rsp_err), 32'(p_err));
      n_ifp++;
      p_cyc = cyc;
    end
    if (p_d) begin
      check("d_rsp_rdata", d_rsp_rdata, p_data);
      n_dp++;
    end
    exp_mreq = busy && !misal && !acc;
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_mreq));
    if (exp_mreq) begin
      check("mem_req_addr", mem_req_addr, e_addr);
      check("mem_req_we", 32'(mem_req_we), 32'(e_we));
      check("mem_req_wdata", mem_req_wdata, e_wdata);
      check("mem_req_be", 32'(mem_req_be), 32'(e_be));
      n_mreq++;
    end
    if_req_valid = ifv; if_req_addr = ifa; flush = fl;
    d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd; d_req_be = dbe;
    if (exp_mreq && stall_n > 0) begin
      mem_req_ready = 0;
      stall_n--;
    end else begin
      mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    mem_rsp_valid = 0;
    mem_rsp_rdata = (mem_fix != 0) ? mem_fix : $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) mem_rsp_valid = 1;
    end else if (spur_en && !acc && $urandom_range(0, 7) == 0) begin
      mem_rsp_valid = 1;
    end
    #1;
    rule(ifv, dv, fl, starve, ig, dg);
    check("if_req_ready", 32'(if_req_ready), 32'(!busy && ig));
    check("d_req_ready", 32'(d_req_ready), 32'(!busy && dg));
    p_if = 0;
    p_d = 0;
    if (!busy) begin
      if (ig) begin
        busy = 1; kd = 0; misal = (ifa[1:0] != 2'b00);
        e_addr = {ifa[31:2], 2'b00}; e_we = 0; e_wdata = 0; e_be = 4'hF;
        starve = 0;
        gq.push_back(0); g_cyc = cyc;
      end else if (dg) begin
        busy = 1; kd = 1; misal = 0;
        e_addr = da; e_we = dwe; e_wdata = dwd; e_be = dbe;
        starve = ifv ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        gq.push_back(1); g_cyc = cyc;
      end
    end else if (misal) begin
      busy = 0; p_if = 1; p_err = 1; p_data = 0;
    end else if (exp_mreq) begin
      if (!kd && fl) disc = 1;
      if (mem_req_ready) begin
        acc = 1;
        mem_cnt = (mem_lat > 0) ? mem_lat : $urandom_range(1, 3);
      end
    end else if (mem_rsp_valid) begin
      busy = 0; acc = 0;
      if (kd) begin
        p_d = 1; p_data = e_we ? 32'h0 : mem_rsp_rdata;
      end else if (!disc && !fl) begin
        p_if = 1; p_err = 0; p_data = mem_rsp_rdata;
      end
      disc = 0;
    end else if (!kd && fl) begin
      disc = 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0);
  endtask

  // Reset lands mid-cycle with both requesters valid; everything must read 0 at once.
  task automatic do_reset();
    @(negedge clock);
    if_req_valid = 1; d_req_valid = 1;
    #2 reset = 0;
    #1;
    check("rst_ctl", 32'({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                          if_rsp_err, mem_req_valid, mem_req_we}), 32'h0);
    check("rst_inst", if_rsp_inst, 32'h0);
    check("rst_rdata", d_rsp_rdata, 32'h0);
    check("rst_maddr", mem_req_addr, 32'h0);
    check("rst_mwdata", mem_req_wdata, 32'h0);
    check("rst_mbe", 32'(mem_req_be), 32'h0);
    if_req_valid = 0; d_req_valid = 0; flush = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    busy = 0; acc = 0; disc = 0; misal = 0; starve = 0; p_if = 0; p_d = 0; stall_n = 0;
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    do_reset();

    mem_fix = 32'h0050_0093;
    n_ifp = 0;
    tick(1, 32'h0001_0000, 0, 32'h0, 0, 32'h0, 4'h0, 0);
    idle(5);
    check("if_pulses", n_ifp, 1);
    check("if_latency", p_cyc - g_cyc, 3);
    check("if_inst_hold", if_rsp_inst, 32'h0050_0093);
    mem_fix = '0;

    stall_n = 2; n_mreq = 0; n_dp = 0;
    tick(0, 32'h0, 1, 32'h0001_0104, 1, 32'hDEAD_BEEF, 4'b0011, 0);
    idle(7);
    check("st_mreq_cycles", n_mreq, 3);
    check("st_pulses", n_dp, 1);
    check("st_rdata", d_rsp_rdata, 32'h0);

    do_reset();
    gq.delete();
    for (int i = 0; i < 32; i++)
      tick(1, 32'h0001_0000 + 32'(4 * i), 1, 32'h0000_2000 + 32'(4 * i), 0, 32'h0, 4'hF, 0);
    idle(4);
    check("starve_ngrants", 32'(gq.size() >= 10), 32'h1);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      check($sformatf("starve_seq%0d", i), 32'(gq[i]), 32'(exp_seq[i]));

    n_ifp = 0;
    tick(1, 32'h0001_0008, 0, 32'h0, 0, 32'h0, 4'h0, 0);
    tick(0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1);
    idle(5);
    check("flush_dropped", n_ifp, 0);
    tick(1, 32'h0001_0040, 0, 32'h0, 0, 32'h0, 4'h0, 0);
    idle(5);
    check("flush_next", n_ifp, 1);

    n_mreq = 0; n_ifp = 0;
    tick(1, 32'h0001_0002, 0, 32'h0, 0, 32'h0, 4'h0, 0);
    idle(4);
    check("mis_nomem", n_mreq, 0);
    check("mis_pulses", n_ifp, 1);
    check("mis_latency", p_cyc - g_cyc, 2);
    check("mis_err_hold", 32'(if_rsp_err), 32'h1);

    mem_lat = 6; n_ifp = 0;
    tick(1, 32'h0001_0010, 0, 32'h0, 0, 32'h0, 4'h0, 0);
    idle(3);
    do_reset();
    idle(8);
    check("late_rsp_ignored", n_ifp, 0);
    check("late_rsp_seen", 32'(mem_cnt), 32'h0);

    mem_lat = 0; rdy_rand = 1; spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = 32'h0001_0000 | 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      tick(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0);
    end
    spur_en = 0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
